pos_frame_rx: RTL and testbench

Receive-side decoder for the two-player paddle link. Takes the byte stream from the UART receiver and reassembles two-byte position frames. Validates each frame and presents the opponent paddle position as `input_pos` to `draw_rect_ctl`. It is the counterpart of the path that serialises `output_pos` for transmission, and it also reports link health.

---
 rtl/pos_link_pkg.sv | 28 ++
 rtl/link_watchdog.sv | 36 +++
 rtl/pos_frame_rx.sv | 134 +++++++++++++
 tb/tb_pos_frame_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pos_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pos_link_pkg
//  Description : Shared frame layout and FSM state type for the paddle link.
//  Revision    : 1.0 - initial release
// ============================================================================
package pos_link_pkg;

    localparam int POS_W = 10;

    // Bit positions within the two frame bytes
    localparam int c_SYNC_BIT   = 7;
    localparam int c_HI_RSV_MSB = 6;
    localparam int c_HI_RSV_LSB = 5;
    localparam int c_LO_PAR_BIT = 6;
    localparam int c_LO_RSV_BIT = 5;

    typedef enum logic [0:0] {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } rx_state_t;

    function automatic logic pos_parity(input logic [POS_W-1:0] pos);
        return ^pos;
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : link_watchdog
//  Description : Idle timer; expired pulses TIMEOUT_CYCLES cycles after kick.
//  Revision    : 1.0 - initial release
// ============================================================================
module link_watchdog #(
    parameter int TIMEOUT_CYCLES = 6_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic kick,
    output logic expired
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    // Zero means disarmed; the last count before zero marks expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (kick) begin
            r_cnt <= c_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign expired = (r_cnt == c_ONE);

endmodule
`default_nettype wire

// File: rtl/pos_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : pos_frame_rx
//  Description : Reassembles and validates two-byte paddle position frames.
//                Macro POS_RX_TIMEOUT_EN enables the link-loss watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module pos_frame_rx
    import pos_link_pkg::*;
#(
    parameter int MAX_POS        = 668,
    parameter int RESET_POS      = 334,
    parameter int TIMEOUT_CYCLES = 6_500_000
) (
    input  logic             clk65MHz,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [POS_W-1:0] input_pos,
    output logic             pos_valid,
    output logic             frame_err,
    output logic [7:0]       err_cnt,
    output logic             link_ok
);

    localparam logic [POS_W-1:0] c_MAX_POS   = POS_W'(MAX_POS);
    localparam logic [POS_W-1:0] c_RESET_POS = POS_W'(RESET_POS);

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [4:0]       r_hi;
    logic [4:0]       w_hi_nxt;
    logic [POS_W-1:0] w_pos;
    logic             w_accept;
    logic             w_reject;
    logic             w_expired;

    logic [POS_W-1:0] r_pos;
    logic             r_pos_valid;
    logic             r_frame_err;
    logic [7:0]       r_err_cnt;
    logic             r_link_ok;

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_HI;
            r_hi    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hi    <= w_hi_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_pos       = {r_hi, rx_data[4:0]};
        if (rx_valid) begin
            if (rx_data[c_SYNC_BIT]) begin
                // A high byte mid-frame abandons the pending frame; one pulse covers it
                if (r_state == WAIT_LO) begin
                    w_reject = 1'b1;
                end
                if (rx_data[c_HI_RSV_MSB:c_HI_RSV_LSB] == 2'b00) begin
                    w_hi_nxt    = rx_data[4:0];
                    w_state_nxt = WAIT_LO;
                end else begin
                    w_reject    = 1'b1;
                    w_state_nxt = WAIT_HI;
                end
            end else begin
                w_state_nxt = WAIT_HI;
                if (r_state == WAIT_HI) begin
                    w_reject = 1'b1;
                end else if (!rx_data[c_LO_RSV_BIT] &&
                             (rx_data[c_LO_PAR_BIT] == pos_parity(w_pos)) &&
                             (w_pos <= c_MAX_POS)) begin
                    w_accept = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
            end
        end
    end

`ifdef POS_RX_TIMEOUT_EN
    link_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_link_watchdog (
        .clk     (clk65MHz),
        .rst_n   (rst_n),
        .kick    (w_accept),
        .expired (w_expired)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
    assign w_expired        = 1'b0;
`endif

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_pos       <= c_RESET_POS;
            r_pos_valid <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_cnt   <= '0;
            r_link_ok   <= 1'b0;
        end else begin
            r_pos_valid <= w_accept;
            r_frame_err <= w_reject;
            if (w_accept) begin
                r_pos <= w_pos;
            end
            if (w_reject && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_accept) begin
                r_link_ok <= 1'b1;
            end else if (w_expired) begin
                r_link_ok <= 1'b0;
            end
        end
    end

    assign input_pos = r_pos;
    assign pos_valid = r_pos_valid;
    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;
    assign link_ok   = r_link_ok;

endmodule
`default_nettype wire

// File: tb/tb_pos_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pos_frame_rx
//  Description : Directed self-checking bench for pos_frame_rx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pos_frame_rx;

    logic       clk65MHz;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] input_pos;
    logic       pos_valid;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       link_ok;

    int n_checks;
    int n_errors;
    int n_pv;
    int n_fe;
    int base_pv;
    int base_fe;

    pos_frame_rx #(
        .MAX_POS        (668),
        .RESET_POS      (334),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk65MHz  (clk65MHz),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .input_pos (input_pos),
        .pos_valid (pos_valid),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .link_ok   (link_ok)
    );

    initial clk65MHz = 1'b0;
    always #5 clk65MHz = ~clk65MHz;

    // Pulse counters sampled mid-cycle
    initial begin
        n_pv = 0;
        n_fe = 0;
    end
    always @(negedge clk65MHz) begin
        if (pos_valid) n_pv = n_pv + 1;
        if (frame_err) n_fe = n_fe + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that samples the byte
    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk65MHz);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk65MHz);
            #1;
        end
    endtask

    task automatic mark();
        base_pv = n_pv;
        base_fe = n_fe;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        check("rst_input_pos", 32'(input_pos), 334);
        check("rst_pos_valid", 32'(pos_valid), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_err_cnt",   32'(err_cnt),   0);
        check("rst_link_ok",   32'(link_ok),   0);

        // Valid frame 336
        mark();
        drive(8'h8A);
        check("t1_no_early_pv", 32'(pos_valid), 0);
        drive(8'h50);
        check("t1_pos_valid", 32'(pos_valid), 1);
        check("t1_input_pos", 32'(input_pos), 336);
        check("t1_link_ok",   32'(link_ok),   1);
        idle(2);
        check("t1_pv_pulses", 32'(n_pv - base_pv), 1);
        check("t1_fe_pulses", 32'(n_fe - base_fe), 0);
        check("t1_err_cnt",   32'(err_cnt), 0);

        // Bad parity
        mark();
        drive(8'h8A);
        drive(8'h10);
        check("t2_frame_err", 32'(frame_err), 1);
        idle(2);
        check("t2_fe_pulses", 32'(n_fe - base_fe), 1);
        check("t2_pv_pulses", 32'(n_pv - base_pv), 0);
        check("t2_input_pos", 32'(input_pos), 336);
        check("t2_err_cnt",   32'(err_cnt), 1);

        // pos=1000 above MAX_POS
        mark();
        drive(8'h9F);
        drive(8'h08);
        check("t3_frame_err", 32'(frame_err), 1);
        idle(2);
        check("t3_fe_pulses", 32'(n_fe - base_fe), 1);
        check("t3_input_pos", 32'(input_pos), 336);
        check("t3_err_cnt",   32'(err_cnt), 2);

        // Resync on consecutive strobes
        mark();
        drive(8'h8A);
        drive(8'h81);
        check("t4_resync_err", 32'(frame_err), 1);
        drive(8'h40);
        check("t4_pos_valid", 32'(pos_valid), 1);
        check("t4_input_pos", 32'(input_pos), 32);
        check("t4_no_err",    32'(frame_err), 0);
        idle(2);
        check("t4_fe_pulses", 32'(n_fe - base_fe), 1);
        check("t4_pv_pulses", 32'(n_pv - base_pv), 1);
        check("t4_err_cnt",   32'(err_cnt), 3);

        // High byte with reserved bits set
        mark();
        drive(8'hA0);
        check("t5_rsv_hi_err", 32'(frame_err), 1);
        idle(1);
        check("t5_err_cnt", 32'(err_cnt), 4);

        // Low byte with reserved bit5 set, otherwise valid 336
        drive(8'h8A);
        drive(8'h70);
        check("t6_rsv_lo_err", 32'(frame_err), 1);
        idle(1);
        check("t6_input_pos", 32'(input_pos), 32);
        check("t6_err_cnt",   32'(err_cnt), 5);

        // 669 rejected, 668 accepted
        drive(8'h94);
        drive(8'h1D);
        check("t7_669_err", 32'(frame_err), 1);
        drive(8'h94);
        drive(8'h5C);
        check("t7_668_pv",  32'(pos_valid), 1);
        check("t7_668_pos", 32'(input_pos), 668);
        idle(1);
        check("t7_err_cnt", 32'(err_cnt), 6);

        // Reset mid-frame
        drive(8'h8A);
        #2;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        idle(1);
        check("t8_input_pos", 32'(input_pos), 334);
        check("t8_link_ok",   32'(link_ok),   0);
        check("t8_err_cnt",   32'(err_cnt),   0);
        mark();
        drive(8'h50);
        check("t8_stray_err", 32'(frame_err), 1);
        idle(2);
        check("t8_fe_pulses", 32'(n_fe - base_fe), 1);
        check("t8_pv_pulses", 32'(n_pv - base_pv), 0);
        check("t8_pos_hold",  32'(input_pos), 334);
        check("t8_link_ok2",  32'(link_ok),   0);

        // Link timeout after one accepted frame
        drive(8'h94);
        drive(8'h5C);
        check("t9_pos_valid", 32'(pos_valid), 1);
        check("t9_link_up",   32'(link_ok),   1);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk65MHz);
            #1;
            if (k == 99) check("t9_link_at_99", 32'(link_ok), 1);
            if (k == 100) begin
`ifdef POS_RX_TIMEOUT_EN
                check("t9_link_at_100", 32'(link_ok), 0);
`else
                check("t9_link_at_100", 32'(link_ok), 1);
`endif
            end
        end
        check("t9_pos_hold", 32'(input_pos), 668);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
